// File: rtl/mmult_result_collector.sv
// Captures mmult results into RES RAM, then replays them over AXI-Stream
// once all datapoints are done, with TLAST on the final beat.
module mmult_result_collector #(
    parameter int width          = 8,
    parameter int m              = 64,
    parameter int RES_depth_bits = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [width-1:0]          mmult_results,
    input  logic                      mmult_particular_datapoint_done,
    input  logic                      mmult_all_datapoints_done,
    output logic                      RES_write_en,
    output logic [RES_depth_bits-1:0] RES_write_address,
    output logic [width-1:0]          RES_write_data_in,
    output logic                      RES_read_en,
    output logic [RES_depth_bits-1:0] RES_read_address,
    input  logic [width-1:0]          RES_read_data,
    output logic [width-1:0]          M_AXIS_TDATA,
    output logic                      M_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,
    output logic                      M_AXIS_TLAST,
    output logic                      stream_done,
    output logic                      overflow
);

    // Counters carry one extra bit so a full RAM (count == m) is representable.
    localparam int CW = RES_depth_bits + 1;
    localparam logic [CW-1:0] M_CNT    = CW'(m);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_READ,
        ST_WAIT,
        ST_LOAD,
        ST_SEND
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             count_q, count_d;
    logic [CW-1:0]             idx_q, idx_d;
    logic [CW-1:0]             total_q, total_d;
    logic                      all_prev_q, all_prev_d;
    logic                      wr_en_q, wr_en_d;
    logic [RES_depth_bits-1:0] wr_addr_q, wr_addr_d;
    logic [width-1:0]          wr_data_q, wr_data_d;
    logic                      rd_en_q, rd_en_d;
    logic [RES_depth_bits-1:0] rd_addr_q, rd_addr_d;
    logic [width-1:0]          tdata_q, tdata_d;
    logic                      tvalid_q, tvalid_d;
    logic                      tlast_q, tlast_d;
    logic                      done_q, done_d;
    logic                      overflow_q, overflow_d;

    logic                      start_edge;
    logic                      capture;
    logic [CW-1:0]             total_new;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        total_d    = total_q;
        all_prev_d = mmult_all_datapoints_done;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_en_d    = rd_en_q;
        rd_addr_d  = rd_addr_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;

        start_edge = mmult_all_datapoints_done & ~all_prev_q;
        capture    = mmult_particular_datapoint_done && (state_q == ST_COLLECT)
                     && (count_q < M_CNT);
        // A strobe landing on the start edge still belongs to this frame.
        total_new  = capture ? (count_q + CNT_ONE) : count_q;

        // Any strobe that cannot be stored (RAM full or busy streaming) is an error.
        if (mmult_particular_datapoint_done && !capture) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_COLLECT: begin
                if (capture) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[RES_depth_bits-1:0];
                    wr_data_d = mmult_results;
                    count_d   = count_q + CNT_ONE;
                end
                if (start_edge) begin
                    total_d = total_new;
                    idx_d   = CNT_ZERO;
                    if (total_new == CNT_ZERO) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                rd_en_d   = 1'b1;
                rd_addr_d = idx_q[RES_depth_bits-1:0];
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tdata_d  = RES_read_data;
                tvalid_d = 1'b1;
                tlast_d  = (idx_q == (total_q - CNT_ONE));
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (M_AXIS_TREADY) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (tlast_q) begin
                        done_d  = 1'b1;
                        count_d = CNT_ZERO;
                        rd_en_d = 1'b0;
                        state_d = ST_COLLECT;
                    end else begin
                        idx_d   = idx_q + CNT_ONE;
                        state_d = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_COLLECT;
            count_q    <= '0;
            idx_q      <= '0;
            total_q    <= '0;
            all_prev_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            total_q    <= total_d;
            all_prev_q <= all_prev_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign RES_write_en      = wr_en_q;
    assign RES_write_address = wr_addr_q;
    assign RES_write_data_in = wr_data_q;
    assign RES_read_en       = rd_en_q;
    assign RES_read_address  = rd_addr_q;
    assign M_AXIS_TDATA      = tdata_q;
    assign M_AXIS_TVALID     = tvalid_q;
    assign M_AXIS_TLAST      = tlast_q;
    assign stream_done       = done_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_mmult_result_collector.sv
// Bench for mmult_result_collector: table-driven scenarios, hand-written corner
// sequences and randomized frames checked against a queue-based model.
module tb_mmult_result_collector;

    localparam int W  = 8;
    localparam int M  = 4;
    localparam int DB = 3;

    logic          clk;
    logic          reset;
    logic [W-1:0]  results;
    logic          strobe;
    logic          all_done;
    logic          wr_en;
    logic [DB-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [DB-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          sdone;
    logic          ovf;

    mmult_result_collector #(.width(W), .m(M), .RES_depth_bits(DB)) dut (
        .clk                             (clk),
        .reset                           (reset),
        .mmult_results                   (results),
        .mmult_particular_datapoint_done (strobe),
        .mmult_all_datapoints_done       (all_done),
        .RES_write_en                    (wr_en),
        .RES_write_address               (wr_addr),
        .RES_write_data_in               (wr_data),
        .RES_read_en                     (rd_en),
        .RES_read_address                (rd_addr),
        .RES_read_data                   (rd_data),
        .M_AXIS_TDATA                    (tdata),
        .M_AXIS_TVALID                   (tvalid),
        .M_AXIS_TREADY                   (tready),
        .M_AXIS_TLAST                    (tlast),
        .stream_done                     (sdone),
        .overflow                        (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RES RAM: 1-cycle synchronous read
    logic [W-1:0] mem [2**DB];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Observed traffic
    logic [15:0] wr_q[$];
    logic [8:0]  beat_q[$];
    logic [7:0]  exp_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          beats_seen = 0;
    bit          prev_v = 0, prev_r = 0, prev_l = 0;
    logic [W-1:0] prev_d = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 0;
            end else begin
                if (wr_en) wr_q.push_back({5'b0, wr_addr, wr_data});
                if (tvalid && tready) begin
                    beat_q.push_back({tlast, tdata});
                    beats_seen++;
                end
                if (prev_v && !prev_r) begin
                    chk("hold_tvalid", int'(tvalid), 1);
                    chk("hold_tdata", int'(tdata), int'(prev_d));
                    chk("hold_tlast", int'(tlast), int'(prev_l));
                end
                if (sdone) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_v = tvalid;
                prev_r = tready;
                prev_d = tdata;
                prev_l = tlast;
            end
        end
    end

    // TREADY: optional forced stall on one beat, otherwise high or random
    int stall_beat = 0;
    int stall_left = 0;
    bit rand_ready = 0;
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && tvalid && beats_seen == stall_beat) begin
                tready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                tready = ($urandom_range(0, 3) != 0);
            end else begin
                tready = 1'b1;
            end
        end
    end

    task automatic drive(input logic s, input logic [W-1:0] v, input logic a);
        @(posedge clk);
        #1;
        strobe   = s;
        results  = v;
        all_done = a;
    endtask

    task automatic clear_obs();
        wr_q.delete();
        beat_q.delete();
        done_cnt   = 0;
        beats_seen = 0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        strobe     = 1'b0;
        results    = '0;
        all_done   = 1'b0;
        stall_left = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_obs();
    endtask

    logic [7:0] cur_vals [8];

    // Strobes n values, raises all_done (optionally with the last strobe),
    // waits for stream_done and returns cycles from the start edge.
    task automatic run_scenario(input int n, input int gap, input bit simul, output int lat);
        bit ad;
        bit edge_now;
        int start_cyc;
        int t;
        ad = 0;
        start_cyc = 0;
        for (int i = 0; i < n; i++) begin
            edge_now = simul && (i == n - 1);
            if (edge_now) ad = 1;
            drive(1'b1, cur_vals[i], ad);
            if (edge_now) start_cyc = cyc;
            for (int g = 1; g < gap; g++) drive(1'b0, '0, ad);
        end
        if (!ad) begin
            drive(1'b0, '0, 1'b1);
            start_cyc = cyc;
        end
        t = 0;
        while (done_cnt == 0 && t < 300) begin
            drive(1'b0, '0, 1'b1);
            t++;
        end
        if (done_cnt == 0) chk("stream_done_timeout", 0, 1);
        lat = done_cyc - start_cyc;
        repeat (6) drive(1'b0, '0, 1'b1);
    endtask

    task automatic build_exp(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++)
            if (exp_q.size() < M) exp_q.push_back(cur_vals[i]);
    endtask

    task automatic check_results(input int exp_ovf);
        int nw;
        int nb;
        chk("wr_count", wr_q.size(), exp_q.size());
        nw = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < nw; i++) begin
            chk("wr_addr", int'(wr_q[i][15:8]), i);
            chk("wr_data", int'(wr_q[i][7:0]), int'(exp_q[i]));
        end
        chk("beat_count", beat_q.size(), exp_q.size());
        nb = (beat_q.size() < exp_q.size()) ? beat_q.size() : exp_q.size();
        for (int i = 0; i < nb; i++) begin
            chk("beat_data", int'(beat_q[i][7:0]), int'(exp_q[i]));
            chk("beat_last", int'(beat_q[i][8]), (i == exp_q.size() - 1) ? 1 : 0);
        end
        chk("done_pulses", done_cnt, 1);
        chk("overflow", int'(ovf), exp_ovf);
    endtask

    typedef struct {
        int n;
        int gap;
        bit simul;
        int stall_beat;
        int stall_len;
        int exp_beats;
        int exp_ovf;
        int exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat;
        int n;
        int gap;
        bit simul;

        vecs[0] = '{n: 4, gap: 8, simul: 0, stall_beat: 0, stall_len: 0, exp_beats: 4, exp_ovf: 0, exp_lat: 17};
        vecs[1] = '{n: 4, gap: 2, simul: 0, stall_beat: 2, stall_len: 5, exp_beats: 4, exp_ovf: 0, exp_lat: 22};
        vecs[2] = '{n: 4, gap: 2, simul: 1, stall_beat: 0, stall_len: 0, exp_beats: 4, exp_ovf: 0, exp_lat: 17};
        vecs[3] = '{n: 5, gap: 2, simul: 0, stall_beat: 0, stall_len: 0, exp_beats: 4, exp_ovf: 1, exp_lat: 17};
        vecs[4] = '{n: 0, gap: 1, simul: 0, stall_beat: 0, stall_len: 0, exp_beats: 0, exp_ovf: 0, exp_lat: 1};
        vecs[5] = '{n: 1, gap: 3, simul: 0, stall_beat: 0, stall_len: 0, exp_beats: 1, exp_ovf: 0, exp_lat: 5};

        reset    = 1'b1;
        strobe   = 1'b0;
        results  = '0;
        all_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_tdata", int'(tdata), 0);
        chk("rst_tvalid", int'(tvalid), 0);
        chk("rst_tlast", int'(tlast), 0);
        chk("rst_stream_done", int'(sdone), 0);
        chk("rst_overflow", int'(ovf), 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < 8; i++) cur_vals[i] = 8'(16 * (i + 1));
            rand_ready = 0;
            stall_beat = vecs[v].stall_beat;
            stall_left = vecs[v].stall_len;
            run_scenario(vecs[v].n, vecs[v].gap, vecs[v].simul, lat);
            build_exp(vecs[v].n);
            chk("table_beats", beat_q.size(), vecs[v].exp_beats);
            chk("table_latency", lat, vecs[v].exp_lat);
            check_results(vecs[v].exp_ovf);
            $display("vec %0d: strobes=%0d beats=%0d latency=%0d overflow=%0d",
                     v, vecs[v].n, beat_q.size(), lat, ovf);
        end

        // Level held high: no restream; low-high re-arms with fresh data at address 0
        do_reset();
        for (int i = 0; i < 8; i++) cur_vals[i] = 8'(16 * (i + 1));
        run_scenario(4, 2, 0, lat);
        build_exp(4);
        check_results(0);
        clear_obs();
        repeat (20) drive(1'b0, '0, 1'b1);
        chk("hold_no_beats", beat_q.size(), 0);
        chk("hold_no_done", done_cnt, 0);
        cur_vals[0] = 8'hA1;
        cur_vals[1] = 8'hB2;
        drive(1'b1, cur_vals[0], 1'b1);
        drive(1'b1, cur_vals[1], 1'b1);
        drive(1'b0, '0, 1'b0);
        run_scenario(0, 1, 0, lat);
        build_exp(2);
        check_results(0);
        $display("rearm: beats=%0d done=%0d", beat_q.size(), done_cnt);

        // Reset while the first beat is stalled in SEND
        do_reset();
        for (int i = 0; i < 8; i++) cur_vals[i] = 8'(16 * (i + 1));
        stall_beat = 0;
        stall_left = 1000;
        for (int i = 0; i < 4; i++) drive(1'b1, cur_vals[i], 1'b0);
        drive(1'b0, '0, 1'b1);
        for (int t = 0; t < 20 && !tvalid; t++) drive(1'b0, '0, 1'b1);
        chk("midrst_tvalid_up", int'(tvalid), 1);
        drive(1'b0, '0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_tvalid", int'(tvalid), 0);
        chk("midrst_tlast", int'(tlast), 0);
        chk("midrst_rd_en", int'(rd_en), 0);
        stall_left = 0;
        do_reset();
        cur_vals[0] = 8'h5A;
        cur_vals[1] = 8'hC3;
        run_scenario(2, 2, 0, lat);
        build_exp(2);
        check_results(0);
        $display("midreset: beats=%0d first_addr=%0d", beat_q.size(),
                 (wr_q.size() > 0) ? int'(wr_q[0][15:8]) : -1);

        // Randomized frames against the queue model
        for (int r = 0; r < 20; r++) begin
            do_reset();
            n     = $urandom_range(0, 6);
            gap   = $urandom_range(1, 3);
            simul = (n > 0) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 8; i++) cur_vals[i] = 8'($urandom);
            rand_ready = 1;
            run_scenario(n, gap, simul, lat);
            build_exp(n);
            check_results((n > M) ? 1 : 0);
            $display("rand %0d: strobes=%0d simul=%0d beats=%0d", r, n, simul, beat_q.size());
        end
        rand_ready = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
